// File: rtl/subinst_fanin_arb5.sv
// subinst_fanin_arb5: five-source round-robin fan-in into a single output
// holding register with valid/ready handshakes on both sides.
// A new word can be loaded in the same cycle the held word is accepted,
// so a continuously ready downstream sees one word per cycle.
// Optional feature macro: SUBINST_FANIN_ARB5_GRANT_CNT_EN adds per-source
// saturating 8-bit grant counters; without it grant_cnt is tied to zero.
module subinst_fanin_arb5 #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          in_valid,
  input  logic [5*DATA_W-1:0] in_data,
  output logic [4:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_src,
  input  logic                out_ready,
  output logic [39:0]         grant_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_last_grant;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_src;
  logic              w_load_slot;
  logic              w_found;
  logic [2:0]        w_grant_idx;
  logic              w_xfer;

  // Round-robin search: first valid source after the last grant, wrapping 4 -> 0
  always_comb begin
    logic [3:0] v_cand;
    w_found     = 1'b0;
    w_grant_idx = 3'd0;
    v_cand      = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      v_cand = {1'b0, r_last_grant} + 4'(k);
      if (v_cand >= 4'd5) v_cand = v_cand - 4'd5;
      if (!w_found && in_valid[v_cand[2:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = v_cand[2:0];
      end
    end
  end

  // Next state and ready: only grant when the holding register is free or draining
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 5'b0;
    w_xfer      = 1'b0;
    w_load_slot = (r_state == ST_EMPTY) || out_ready;
    if (w_load_slot && w_found) begin
      in_ready[w_grant_idx] = 1'b1;
      w_xfer                = 1'b1;
    end
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Holding register and priority pointer; last_grant resets to 4 so source 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_src        <= 3'd0;
      r_last_grant <= 3'd4;
    end else if (w_xfer) begin
      r_data       <= in_data[w_grant_idx*DATA_W +: DATA_W];
      r_src        <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

`ifdef SUBINST_FANIN_ARB5_GRANT_CNT_EN
  logic [4:0][7:0] r_grant_cnt;

  // Per-source grant counters, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_xfer && (w_grant_idx == 3'(i)) && (r_grant_cnt[i] != 8'hFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 8'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`else
  assign grant_cnt = 40'd0;
`endif

endmodule

// File: tb/tb_subinst_fanin_arb5.sv
// Directed bench for subinst_fanin_arb5 with a reference model of the
// round-robin arbiter and a queue of expected output words.
module tb_subinst_fanin_arb5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid;
  logic [39:0] in_data;
  logic [4:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_src;
  logic        out_ready;
  logic [39:0] grant_cnt;

  int tests = 0;
  int fails = 0;

  // model state
  logic        m_full;
  int          m_last;
  logic [7:0]  m_data;
  logic [2:0]  m_src;
  int          m_cnt[5];
  logic [10:0] exp_q[$];

  subinst_fanin_arb5 #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [4:0] v, input int last);
    for (int k = 1; k <= 5; k++) begin
      int idx;
      idx = (last + k) % 5;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [39:0] exp_cnt();
    logic [39:0] r;
    r = '0;
`ifdef SUBINST_FANIN_ARB5_GRANT_CNT_EN
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(m_cnt[i]);
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_last = 4;
    m_data = 8'h00;
    m_src  = 3'd0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
    check({tag, ".out_data"},  64'(out_data),  64'(m_data));
    check({tag, ".out_src"},   64'(out_src),   64'(m_src));
    check({tag, ".grant_cnt"}, 64'(grant_cnt), 64'(exp_cnt()));
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input string tag, input logic [4:0] v, input logic [39:0] d,
                      input logic rdy, output int g);
    logic [4:0]  exp_rdy;
    logic [10:0] e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #3;
    g = (!m_full || rdy) ? rr_pick(v, m_last) : -1;
    exp_rdy = (g >= 0) ? (5'b00001 << g) : 5'b0;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (g >= 0) begin
      exp_q.push_back({3'(g), d[g*8 +: 8]});
      m_last = g;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      e      = exp_q.pop_front();
      m_src  = e[10:8];
      m_data = e[7:0];
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    check_outputs(tag);
  endtask

  // Async reset pulse; called at posedge+1, returns at posedge+1.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".async_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".async_out_data"},  64'(out_data),  64'd0);
    check({tag, ".async_out_src"},   64'(out_src),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    logic [39:0] d;
    logic [7:0]  held;
    logic [4:0]  order_v;
    rst_n     = 1'b0;
    in_valid  = 5'b0;
    in_data   = 40'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;

    // single source 0 handshake, latency one cycle
    step("single", 5'b00001, 40'h00_0000_00A5, 1'b1, g);
    check("single.grant", 64'(g), 64'd0);
    check("single.word", {56'd0, out_data}, 64'hA5);
    step("drain", 5'b00000, 40'd0, 1'b1, g);

    // all sources requesting: rotating order from source 0
    pulse_reset("rst_rr");
    for (int c = 0; c < 10; c++) begin
      d = {$urandom, 8'($urandom)};
      step("all5", 5'b11111, d, 1'b1, g);
      check("all5.order", 64'(g), 64'(c % 5));
    end
    step("all5_drain", 5'b00000, 40'd0, 1'b1, g);

    // backpressure: held while out_ready low, then immediate regrant
    step("bp_fill", 5'b00010, 40'h00_0000_3C00, 1'b1, g);
    held = out_data;
    for (int c = 0; c < 4; c++) begin
      step("bp_hold", 5'b00100, 40'h00_0077_0000, 1'b0, g);
      check("bp_hold.stable", 64'(out_data), 64'(held));
    end
    step("bp_release", 5'b00100, 40'h00_0077_0000, 1'b1, g);
    check("bp_release.grant", 64'(g), 64'd2);
    step("bp_drain", 5'b00000, 40'd0, 1'b1, g);

    // wrap from 3 to 0, then back to 3
    step("wrap_set3", 5'b01000, 40'h00_1100_0000, 1'b1, g);
    step("wrap_to0", 5'b01001, 40'h00_2200_0033, 1'b1, g);
    check("wrap_to0.grant", 64'(g), 64'd0);
    step("wrap_to3", 5'b01001, 40'h00_4400_0055, 1'b1, g);
    check("wrap_to3.grant", 64'(g), 64'd3);

    // reset while FULL, then source 0 first
    step("pre_rst_hold", 5'b10000, 40'h99_0000_0000, 1'b0, g);
    pulse_reset("rst_full");
    step("post_rst", 5'b10001, 40'hEE_0000_0011, 1'b1, g);
    check("post_rst.grant", 64'(g), 64'd0);
    step("post_rst2", 5'b10001, 40'hEE_0000_0011, 1'b1, g);
    check("post_rst2.grant", 64'(g), 64'd4);

    // random traffic with random backpressure
    for (int c = 0; c < 60; c++) begin
      order_v = 5'($urandom);
      d = {$urandom, 8'($urandom)};
      step("rand", order_v, d, 1'($urandom_range(0, 1)), g);
    end

    // counter saturation on source 1
    pulse_reset("rst_cnt");
    for (int c = 0; c < 300; c++) begin
      step("cnt", 5'b00010, {24'd0, 8'(c), 8'd0}, 1'b1, g);
    end
`ifdef SUBINST_FANIN_ARB5_GRANT_CNT_EN
    check("cnt.final", 64'(grant_cnt), 64'h00_0000_FF00);
`else
    check("cnt.final", 64'(grant_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
